sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator.sv | 91 +++++++++
 tb/tb_sum_accumulator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Frame accumulator for WIDTH+1-bit adder samples, with a sticky overflow flag and ready/valid handshakes.
// Defining SUM_ACCUMULATOR_SAT_EN clamps acc on overflow; without it the sum wraps modulo 2^ACC_WIDTH.
module sum_accumulator #(
  parameter int WIDTH     = 8,
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = WIDTH + 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH:0]               in_sum,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_WIDTH-1:0]         out_acc,
  output logic [$clog2(COUNT+1)-1:0]   out_count,
  output logic                         out_ovf
);

  localparam int CW = $clog2(COUNT + 1);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CW-1:0]        cnt;
  logic                 ovf;

  logic                 accept;
  logic                 last;
  logic [ACC_WIDTH:0]   in_ext;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 ovf_next;
  logic [ACC_WIDTH-1:0] acc_next;

  assign accept  = (state == ACCUM) && in_valid;
  assign last    = (cnt == CW'(COUNT - 1));
  assign in_ext  = {{(ACC_WIDTH - WIDTH){1'b0}}, in_sum};
  assign sum_ext = {1'b0, acc} + in_ext;

  // The extra MSB of sum_ext is the carry out of the ACC_WIDTH-bit accumulator.
  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    ovf_next = ovf | sum_ext[ACC_WIDTH];
    acc_next = sum_ext[ACC_WIDTH-1:0];
`ifdef SUM_ACCUMULATOR_SAT_EN
    if (ovf_next) acc_next = '1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt + CW'(1);
            ovf <= ovf_next;
            if (last || flush) state <= HOLD;
          end else if (flush && (cnt != '0)) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          // The consume cycle only clears state; the next sample is taken a cycle later.
          if (out_ready) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign out_acc   = acc;
  assign out_count = cnt;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: directed requirement scenarios plus randomized traffic
// compared against a frame-level model (sample queue summed with plain arithmetic).
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [8:0] in_sum;
  logic       flush;
  logic       out_ready;

  logic        in_ready0, out_valid0, out_ovf0;
  logic [11:0] out_acc0;
  logic [2:0]  out_count0;
  logic        in_ready1, out_valid1, out_ovf1;
  logic [9:0]  out_acc1;
  logic [2:0]  out_count1;

  int n_cmp = 0;
  int n_err = 0;

  // Frame-level reference: holding flag plus the samples accepted in the current frame.
  bit          m_hold;
  int unsigned m_q[$];

  always #5 clk = ~clk;

  sum_accumulator dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_sum(in_sum),
    .flush(flush), .out_valid(out_valid0), .out_ready(out_ready), .out_acc(out_acc0),
    .out_count(out_count0), .out_ovf(out_ovf0)
  );

  sum_accumulator #(.WIDTH(8), .COUNT(4), .ACC_WIDTH(10)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_sum(in_sum),
    .flush(flush), .out_valid(out_valid1), .out_ready(out_ready), .out_acc(out_acc1),
    .out_count(out_count1), .out_ovf(out_ovf1)
  );

  function automatic void frame_exp(input int accw, output logic [31:0] acc, output logic ovf);
    longint t = 0;
    longint lim = longint'(1) << accw;
    foreach (m_q[i]) t += m_q[i];
    ovf = (t >= lim);
`ifdef SUM_ACCUMULATOR_SAT_EN
    acc = ovf ? 32'(lim - 1) : 32'(t);
`else
    acc = 32'(t % lim);
`endif
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, leave time #1 after it.
  task automatic drive(input logic v, input logic [8:0] s, input logic f, input logic r,
                       input logic rs);
    @(negedge clk);
    rst = rs; in_valid = v; in_sum = s; flush = f; out_ready = r;
    @(posedge clk);
    if (rs) begin
      m_hold = 1'b0;
      m_q.delete();
    end else if (!m_hold) begin
      if (v) m_q.push_back(int'(s));
      if ((m_q.size() == 4) || (f && (m_q.size() > 0))) m_hold = 1'b1;
    end else if (r) begin
      m_hold = 1'b0;
      m_q.delete();
    end
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 9'd77, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready0); end
    n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid0); end
    n_cmp++; if (out_acc0 !== 12'd0) begin n_err++; $display("FAIL reset_out_acc: got %0d want 0", out_acc0); end
    n_cmp++; if (out_count0 !== 3'd0) begin n_err++; $display("FAIL reset_out_count: got %0d want 0", out_count0); end
    n_cmp++; if (out_ovf0 !== 1'b0) begin n_err++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf0); end
  endtask

  task automatic test_basic_frame;
    drive(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 9'd10, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 9'd20, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 9'd30, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", out_valid0); end
    drive(1'b1, 9'd40, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (out_valid0 !== 1'b1) begin n_err++; $display("FAIL basic_out_valid: got %b want 1", out_valid0); end
    n_cmp++; if (out_acc0 !== 12'd100) begin n_err++; $display("FAIL basic_out_acc: got %0d want 100", out_acc0); end
    n_cmp++; if (out_count0 !== 3'd4) begin n_err++; $display("FAIL basic_out_count: got %0d want 4", out_count0); end
    n_cmp++; if (out_ovf0 !== 1'b0) begin n_err++; $display("FAIL basic_out_ovf: got %b want 0", out_ovf0); end
    // Consume cycle: a valid sample offered here must not be taken.
    drive(1'b1, 9'd99, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL basic_idle_ready: got %b want 1", in_ready0); end
    n_cmp++; if (out_acc0 !== 12'd0) begin n_err++; $display("FAIL basic_idle_acc: got %0d want 0", out_acc0); end
  endtask

  task automatic test_flush;
    drive(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 9'd5, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 9'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid0 !== 1'b1) begin n_err++; $display("FAIL flush_out_valid: got %b want 1", out_valid0); end
    n_cmp++; if (out_acc0 !== 12'd12) begin n_err++; $display("FAIL flush_out_acc: got %0d want 12", out_acc0); end
    n_cmp++; if (out_count0 !== 3'd2) begin n_err++; $display("FAIL flush_out_count: got %0d want 2", out_count0); end
    drive(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 9'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL flush_empty_valid: got %b want 0", out_valid0); end
    n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL flush_empty_ready: got %b want 1", in_ready0); end
    drive(1'b1, 9'd6, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_count0 !== 3'd1) begin n_err++; $display("FAIL flush_single_count: got %0d want 1", out_count0); end
    n_cmp++; if (out_acc0 !== 12'd6) begin n_err++; $display("FAIL flush_single_acc: got %0d want 6", out_acc0); end
  endtask

  task automatic test_flush_with_sample_hold;
    drive(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 9'd3, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'd9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 9'd200, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (in_ready0 !== 1'b0) begin n_err++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready0); end
      n_cmp++; if (out_valid0 !== 1'b1) begin n_err++; $display("FAIL hold_out_valid[%0d]: got %b want 1", i, out_valid0); end
      n_cmp++; if (out_acc0 !== 12'd12) begin n_err++; $display("FAIL hold_out_acc[%0d]: got %0d want 12", i, out_acc0); end
      n_cmp++; if (out_count0 !== 3'd2) begin n_err++; $display("FAIL hold_out_count[%0d]: got %0d want 2", i, out_count0); end
    end
    drive(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL hold_release_ready: got %b want 1", in_ready0); end
  endtask

  task automatic test_overflow;
    logic [9:0] want;
`ifdef SUM_ACCUMULATOR_SAT_EN
    want = 10'd1023;
`else
    want = 10'd1020;
`endif
    drive(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 9'd511, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (out_valid1 !== 1'b1) begin n_err++; $display("FAIL ovf_out_valid: got %b want 1", out_valid1); end
    n_cmp++; if (out_acc1 !== want) begin n_err++; $display("FAIL ovf_out_acc: got %0d want %0d", out_acc1, want); end
    n_cmp++; if (out_ovf1 !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", out_ovf1); end
    n_cmp++; if (out_acc0 !== 12'd2044) begin n_err++; $display("FAIL ovf_wide_acc: got %0d want 2044", out_acc0); end
    n_cmp++; if (out_ovf0 !== 1'b0) begin n_err++; $display("FAIL ovf_wide_flag: got %b want 0", out_ovf0); end
    drive(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (out_ovf1 !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", out_ovf1); end
  endtask

  task automatic test_reset_mid_frame;
    drive(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 9'd50, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'd60, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'd70, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (out_acc0 !== 12'd0) begin n_err++; $display("FAIL rmid_acc: got %0d want 0", out_acc0); end
    n_cmp++; if (out_count0 !== 3'd0) begin n_err++; $display("FAIL rmid_count: got %0d want 0", out_count0); end
    for (int i = 0; i < 4; i++) drive(1'b1, 9'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL rhold_valid: got %b want 0", out_valid0); end
    n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL rhold_ready: got %b want 1", in_ready0); end
    n_cmp++; if (out_acc0 !== 12'd0) begin n_err++; $display("FAIL rhold_acc: got %0d want 0", out_acc0); end
    for (int i = 0; i < 4; i++) drive(1'b1, 9'd1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (out_acc0 !== 12'd4) begin n_err++; $display("FAIL rnext_acc: got %0d want 4", out_acc0); end
    n_cmp++; if (out_count0 !== 3'd4) begin n_err++; $display("FAIL rnext_count: got %0d want 4", out_count0); end
  endtask

  task automatic test_random;
    logic [31:0] e_acc;
    logic        e_ovf;
    logic [8:0]  s;
    drive(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 600; c++) begin
      s = ($urandom_range(3) == 0) ? 9'd511 : 9'($urandom_range(511));
      drive(1'($urandom_range(99) < 60), s, 1'($urandom_range(99) < 15),
            1'($urandom_range(99) < 40), 1'($urandom_range(99) < 2));
      n_cmp++;
      if (in_ready0 !== !m_hold || in_ready1 !== !m_hold) begin
        n_err++; $display("FAIL rnd_in_ready[%0d]: got %b/%b want %b", c, in_ready0, in_ready1, !m_hold);
      end
      n_cmp++;
      if (out_valid0 !== m_hold || out_valid1 !== m_hold) begin
        n_err++; $display("FAIL rnd_out_valid[%0d]: got %b/%b want %b", c, out_valid0, out_valid1, m_hold);
      end
      if (m_hold) begin
        n_cmp++;
        if (int'(out_count0) != m_q.size() || int'(out_count1) != m_q.size()) begin
          n_err++; $display("FAIL rnd_count[%0d]: got %0d/%0d want %0d", c, out_count0, out_count1, m_q.size());
        end
        frame_exp(12, e_acc, e_ovf);
        n_cmp++;
        if ({20'd0, out_acc0} !== e_acc || out_ovf0 !== e_ovf) begin
          n_err++; $display("FAIL rnd_acc12[%0d]: got %0d ovf %b want %0d ovf %b", c, out_acc0, out_ovf0, e_acc, e_ovf);
        end
        frame_exp(10, e_acc, e_ovf);
        n_cmp++;
        if ({22'd0, out_acc1} !== e_acc || out_ovf1 !== e_ovf) begin
          n_err++; $display("FAIL rnd_acc10[%0d]: got %0d ovf %b want %0d ovf %b", c, out_acc1, out_ovf1, e_acc, e_ovf);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; flush = 1'b0; out_ready = 1'b0;
    m_hold = 1'b0;
    test_reset();
    test_basic_frame();
    test_flush();
    test_flush_with_sample_hold();
    test_overflow();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
